// File: rtl/sram_arbiter3.sv
// Three-port arbiter for the shared 8-bit board SRAM: p0 (video) has priority,
// p1/p2 share round-robin, and a starvation counter guarantees p1/p2 a slot.
module sram_arbiter3 #(
    parameter int AW         = 18,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_din,
    output logic [DW-1:0] p0_dout,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_din,
    output logic [DW-1:0] p1_dout,
    output logic          p1_ack,
    input  logic          p2_req,
    input  logic          p2_we,
    input  logic [AW-1:0] p2_addr,
    input  logic [DW-1:0] p2_din,
    output logic [DW-1:0] p2_dout,
    output logic          p2_ack,
    output logic [AW-1:0] sa,
    inout  wire  [DW-1:0] sd,
    output logic          sramwe_n,
    output logic          busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RECOVER} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      req_v, we_v;
    logic [AW-1:0]   addr_v [3];
    logic [DW-1:0]   din_v  [3];
    logic            low_pend, p0_win;
    logic [1:0]      win_sel, win_reg;
    logic [SW-1:0]   starve_cnt_reg;
    logic            rr_last_reg;   // 1 = p2 had the last low-group grant
    logic [AW-1:0]   sa_reg;
    logic [DW-1:0]   sd_out_reg;
    logic            sd_oe_reg, we_n_reg, wr_reg;
    logic [2:0]      ack_reg;
    logic [DW-1:0]   dout_reg [3];

    assign req_v = {p2_req, p1_req, p0_req};
    assign we_v  = {p2_we, p1_we, p0_we};
    assign addr_v[0] = p0_addr;
    assign addr_v[1] = p1_addr;
    assign addr_v[2] = p2_addr;
    assign din_v[0]  = p0_din;
    assign din_v[1]  = p1_din;
    assign din_v[2]  = p2_din;

    always_comb begin
        win_sel  = 2'd0;
        low_pend = p1_req | p2_req;
        p0_win   = p0_req && !(low_pend && starve_cnt_reg == SW'(STARVE_MAX));
        if (!p0_win) begin
            if (p1_req && p2_req)
                win_sel = rr_last_reg ? 2'd1 : 2'd2;
            else if (p1_req)
                win_sel = 2'd1;
            else
                win_sel = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (|req_v) state_next = ST_ACCESS;
            ST_ACCESS:  state_next = ST_RECOVER;
            ST_RECOVER: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_reg        <= 2'd0;
            sa_reg         <= '0;
            sd_out_reg     <= '0;
            sd_oe_reg      <= 1'b0;
            we_n_reg       <= 1'b1;
            wr_reg         <= 1'b0;
            ack_reg        <= 3'b000;
            starve_cnt_reg <= '0;
            rr_last_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: if (|req_v) begin
                    win_reg    <= win_sel;
                    sa_reg     <= addr_v[win_sel];
                    wr_reg     <= we_v[win_sel];
                    sd_out_reg <= din_v[win_sel];
                    sd_oe_reg  <= we_v[win_sel];
                    we_n_reg   <= ~we_v[win_sel];
                    if (win_sel == 2'd0) begin
                        if (!low_pend)
                            starve_cnt_reg <= '0;
                        else if (starve_cnt_reg != SW'(STARVE_MAX))
                            starve_cnt_reg <= starve_cnt_reg + SW'(1);
                    end else begin
                        starve_cnt_reg <= '0;
                        rr_last_reg    <= (win_sel == 2'd2);
                    end
                end
                ST_ACCESS: begin
                    we_n_reg <= 1'b1;
                    ack_reg  <= 3'b001 << win_reg;
                end
                ST_RECOVER: begin
                    // Write data stays on the bus one cycle past the WE rising edge.
                    ack_reg   <= 3'b000;
                    sd_oe_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) dout_reg[i] <= '0;
        end else if (state_reg == ST_ACCESS && !wr_reg) begin
            for (int i = 0; i < 3; i++)
                if (win_reg == 2'(i)) dout_reg[i] <= sd;
        end
    end

    assign sd       = sd_oe_reg ? sd_out_reg : {DW{1'bz}};
    assign sa       = sa_reg;
    assign sramwe_n = we_n_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign p0_ack   = ack_reg[0];
    assign p1_ack   = ack_reg[1];
    assign p2_ack   = ack_reg[2];
    assign p0_dout  = dout_reg[0];
    assign p1_dout  = dout_reg[1];
    assign p2_dout  = dout_reg[2];
endmodule

// File: doc/sram_arbiter3.md
Name: sram_arbiter3

Overview:
- Shares the single external 8-bit SRAM between three requesters: p0 = video fetch (highest priority), p1 = CPU, p2 = auxiliary master (tape/DMA loader).
- Each port uses a level request / single-cycle acknowledge handshake.
- Issues one SRAM access per 3-cycle slot.
- Sits between the ULA/CPU bus logic and the board SRAM pins, replacing edge-detected bank multiplexing with an explicit handshake and starvation control.

Parameters:
AW, 18, SRAM address width
DW, 8, data width
STARVE_MAX, 4, maximum consecutive p0 grants while p1/p2 are waiting

Ports:
clk  in  1  system clock; all flops on rising edge
rst  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 request; held high until p0_ack
p0_we  in  1  1 = write, 0 = read; valid while p0_req
p0_addr  in  AW  port 0 address
p0_din  in  DW  port 0 write data
p0_dout  out  DW  port 0 read data; valid from the p0_ack cycle until the next p0 read completes
p0_ack  out  1  one-cycle completion pulse
p1_req, p1_we, p1_addr, p1_din, p1_dout, p1_ack  same as p0, for port 1
p2_req, p2_we, p2_addr, p2_din, p2_dout, p2_ack  same as p0, for port 2
sa  out  AW  SRAM address
sd  inout  DW  SRAM data; driven only during writes, otherwise high-Z
sramwe_n  out  1  SRAM write enable, active low
busy  out  1  high in ACCESS and RECOVER

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, sa=0, sd=Z, sramwe_n=1
  - all ack=0, all dout=0, busy=0
  - starve_cnt=0, rr_last=p2 (so p1 wins the first low-group tie)
- States:
  - IDLE: if no req, stay. Otherwise select the winner and latch winner addr into sa, we into wr_r, din into the sd drive register. sd_oe=wr_r. sramwe_n<=~we. Go to ACCESS.
  - ACCESS: sramwe_n<=1. If read, winner dout<=sd. Winner ack<=1. Go to RECOVER.
  - RECOVER: all ack<=0. sd released to Z (write data held one cycle past the WE rising edge). Go to IDLE.
- Timing:
  - Request sampled at edge n (state IDLE). Ack is high during cycle n+2 (the RECOVER state).
  - Back-to-back throughput: one access per 3 clocks.
- Handshake:
  - Requester must hold req/we/addr/din stable until ack. Values are latched at the grant edge, so later changes do not affect the current access.
  - Req still high in the IDLE cycle after ack is a new transaction.
  - A registered requester that drops req on the ack edge gets exactly one access.
- Winner selection in IDLE:
  - low_pend = p1_req | p2_req.
  - If p0_req and not (low_pend and starve_cnt==STARVE_MAX): p0 wins.
  - Else p1 and p2 arbitrate round-robin. If both request, the one not equal to rr_last wins; otherwise the sole requester wins. rr_last<=winner.
- Starve counter:
  - p0 granted while low_pend: starve_cnt++ (saturates at STARVE_MAX).
  - p1/p2 granted, or p0 granted with no low_pend: starve_cnt<=0.
- Simultaneous events:
  - All three requesting: order is p0, p1, p2. With all held continuously and STARVE_MAX=4, the pattern is p0×4, then a low port, repeating, with the low grants alternating p1/p2.
- Reset mid-operation:
  - The access is abandoned. sramwe_n returns to 1 immediately and sd goes Z.
  - No ack is issued for the aborted transfer.
- Restrictions:
  - Only one port is acked at a time; acks are mutually exclusive.
  - dout of the non-winning ports is never modified.
  - sramwe_n is never low for more than one cycle.
  - sd is never driven while sramwe_n=1 in IDLE.

Test Plan:
- Reset: assert rst during ACCESS of a p1 write → sramwe_n=1, sd=Z, all acks 0, busy=0 asynchronously; after release, the first grant of a tie between p1 and p2 goes to p1.
- Single port: p1 write addr 0x01234 data 0xA5, then read 0x01234 → sramwe_n low exactly one cycle with sa=0x01234 and sd=0xA5; read gives p1_dout=0xA5 with p1_ack 2 cycles after the grant edge.
- Tie: p0, p1 and p2 all assert req in the same cycle with distinct addresses, each dropping on its ack → grant order p0, p1, p2; acks 3 cycles apart with no overlap.
- Starvation: p0_req held high continuously, p1 read request pending → p0 acked 4 times, then p1_ack on the 5th slot; starve_cnt returns to 0.
- Round-robin: p1 and p2 held high, p0 idle, 6 slots → grants p1, p2, p1, p2, p1, p2; p0 asserted mid-sequence wins the next slot.
- Isolation: p2 read of 0x3FFFF (preloaded 0x5C) while p1_dout=0x11 → p2_dout=0x5C, p1_dout stays 0x11, sd high-Z throughout.
